// File: rtl/game_pkg.sv
// Shared encodings for the game status block: screen/level codes, status FSM
// states, per-level brick counts and datapath widths.
package game_pkg;

   localparam int unsigned CODE_W       = 4;
   localparam int unsigned LIVES_W      = 2;
   localparam int unsigned BRICKS_W     = 6;
   localparam int unsigned SCORE_W      = 16;
   localparam int unsigned BRICK_POINTS = 10;

   // Screen/level codes driven by the level state machine
   typedef enum logic [CODE_W-1:0] {
      SCR_LS = 4'd1,
      SCR_GO = 4'd2,
      SCR_L1 = 4'd3,
      SCR_L2 = 4'd4,
      SCR_L3 = 4'd5,
      SCR_L4 = 4'd6,
      SCR_L5 = 4'd7,
      SCR_L6 = 4'd8,
      SCR_L7 = 4'd9,
      SCR_L8 = 4'd10,
      SCR_SM = 4'd15
   } screen_e;

   // Status FSM states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_PLAY = 3'd2,
      ST_WON  = 3'd3,
      ST_LOST = 3'd4
   } status_e;

   // Bricks granted on entry to each level
   localparam logic [BRICKS_W-1:0] BRICKS_L1 = 6'd6;
   localparam logic [BRICKS_W-1:0] BRICKS_L2 = 6'd12;
   localparam logic [BRICKS_W-1:0] BRICKS_L3 = 6'd18;
   localparam logic [BRICKS_W-1:0] BRICKS_L4 = 6'd24;
   localparam logic [BRICKS_W-1:0] BRICKS_L5 = 6'd30;
   localparam logic [BRICKS_W-1:0] BRICKS_L6 = 6'd36;
   localparam logic [BRICKS_W-1:0] BRICKS_L7 = 6'd42;
   localparam logic [BRICKS_W-1:0] BRICKS_L8 = 6'd48;

   // True when the code names a playable level (L1..L8)
   function automatic logic is_level(input logic [CODE_W-1:0] code);
      return (code >= SCR_L1) && (code <= SCR_L8);
   endfunction

endpackage

// File: rtl/level_brick_rom.sv
// Combinational level-code to brick-count lookup; non-level codes give 0.
module level_brick_rom
   import game_pkg::*;
(
   input  logic [CODE_W-1:0]   level_code,
   output logic [BRICKS_W-1:0] bricks_c
);

   // Table lookup
   always_comb begin
      bricks_c = '0;
      case (level_code)
         SCR_L1:  bricks_c = BRICKS_L1;
         SCR_L2:  bricks_c = BRICKS_L2;
         SCR_L3:  bricks_c = BRICKS_L3;
         SCR_L4:  bricks_c = BRICKS_L4;
         SCR_L5:  bricks_c = BRICKS_L5;
         SCR_L6:  bricks_c = BRICKS_L6;
         SCR_L7:  bricks_c = BRICKS_L7;
         SCR_L8:  bricks_c = BRICKS_L8;
         default: bricks_c = '0;
      endcase
   end

endmodule

// File: rtl/game_status.sv
// Game status tracker: bricks, lives, win/lose flags and optional score for
// the current level. Define GAME_STATUS_SCORE_EN to build the score counter;
// without it the score output is tied to zero.
module game_status
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT = 3,
   parameter int unsigned WIN_BONUS  = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CODE_W-1:0]   current_state,
   input  logic                brick_hit,
   input  logic                ball_lost,
   output logic                win,
   output logic                lose,
   output logic [LIVES_W-1:0]  lives,
   output logic [BRICKS_W-1:0] bricks_left,
   output logic [SCORE_W-1:0]  score
);

   if ((LIVES_INIT < 1) || (LIVES_INIT > 3) || (WIN_BONUS > 65535)) begin : g_bad_param
      $error("game_status: LIVES_INIT or WIN_BONUS out of range");
   end

   status_e               state_q, state_d;
   logic [CODE_W-1:0]     level_q, level_d;
   logic [LIVES_W-1:0]    lives_q, lives_d;
   logic [BRICKS_W-1:0]   bricks_q, bricks_d;
   logic                  win_q, win_d;
   logic                  lose_q, lose_d;
   logic [BRICKS_W-1:0]   rom_bricks_c;
   logic                  in_level_c;
   logic                  last_brick_c;
   logic                  last_life_c;

   level_brick_rom u_rom (
      .level_code (current_state),
      .bricks_c   (rom_bricks_c)
   );

   assign in_level_c = is_level(current_state);

   // State and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         level_q  <= '0;
         lives_q  <= '0;
         bricks_q <= '0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         lives_q  <= lives_d;
         bricks_q <= bricks_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
      end
   end

   // Next state, counter updates and win/lose flags
   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      lives_d      = lives_q;
      bricks_d     = bricks_q;
      last_brick_c = 1'b0;
      last_life_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_level_c) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!in_level_c) begin
               state_d = ST_IDLE;
            end else begin
               bricks_d = rom_bricks_c;
               lives_d  = LIVES_W'(LIVES_INIT);
               level_d  = current_state;
               state_d  = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (!in_level_c) begin
               state_d = ST_IDLE;
            end else if (current_state != level_q) begin
               state_d = ST_ARM;
            end else begin
               if (brick_hit && (bricks_q != '0)) begin
                  bricks_d     = bricks_q - BRICKS_W'(1);
                  last_brick_c = (bricks_q == BRICKS_W'(1));
               end
               if (ball_lost && (lives_q != '0)) begin
                  lives_d     = lives_q - LIVES_W'(1);
                  last_life_c = (lives_q == LIVES_W'(1));
               end
               // Clearing the level wins even if the last ball went too
               if (last_brick_c)     state_d = ST_WON;
               else if (last_life_c) state_d = ST_LOST;
            end
         end
         ST_WON, ST_LOST: begin
            if (!in_level_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      win_d  = (state_d == ST_WON);
      lose_d = (state_d == ST_LOST);
   end

   assign win         = win_q;
   assign lose        = lose_q;
   assign lives       = lives_q;
   assign bricks_left = bricks_q;

`ifdef GAME_STATUS_SCORE_EN
   localparam int unsigned SUM_W = SCORE_W + 2;

   logic [SCORE_W-1:0] score_q, score_d;
   logic [SUM_W-1:0]   score_sum_c;
   logic               hit_ok_c;
   logic               won_entry_c;

   assign hit_ok_c    = (state_q == ST_PLAY) && in_level_c && (current_state == level_q)
                        && brick_hit && (bricks_q != '0);
   assign won_entry_c = (state_d == ST_WON) && (state_q != ST_WON);

   // Score register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) score_q <= '0;
      else     score_q <= score_d;
   end

   // Saturating score accumulation, cleared on the start menu
   always_comb begin
      score_d     = score_q;
      score_sum_c = SUM_W'(score_q);
      if (hit_ok_c)    score_sum_c = score_sum_c + SUM_W'(BRICK_POINTS);
      if (won_entry_c) score_sum_c = score_sum_c + SUM_W'(WIN_BONUS);
      if (current_state == SCR_SM)            score_d = '0;
      else if (|score_sum_c[SUM_W-1:SCORE_W]) score_d = '1;
      else                                    score_d = score_sum_c[SCORE_W-1:0];
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_game_status.sv
// Self-checking bench for game_status with a cycle-level reference model.
module tb_game_status;
   import game_pkg::*;

   localparam int unsigned LIVES_INIT = 3;
   localparam int unsigned WIN_BONUS  = 100;
`ifdef GAME_STATUS_SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cs;
   logic        h;
   logic        l;
   logic        win;
   logic        lose;
   logic [1:0]  lives;
   logic [5:0]  bricks_left;
   logic [15:0] score;

   int n_tests = 0;
   int n_fail  = 0;

   game_status #(.LIVES_INIT(LIVES_INIT), .WIN_BONUS(WIN_BONUS)) dut (
      .clk           (clk),
      .rst           (rst),
      .current_state (cs),
      .brick_hit     (h),
      .ball_lost     (l),
      .win           (win),
      .lose          (lose),
      .lives         (lives),
      .bricks_left   (bricks_left),
      .score         (score)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_ARM, M_PLAY, M_WON, M_LOST} mphase_e;
   mphase_e m_phase = M_IDLE;
   int m_bricks = 0;
   int m_lives  = 0;
   int m_level  = 0;
   int m_score  = 0;

   function automatic bit is_lvl(input int c);
      return (c >= 3) && (c <= 10);
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE; m_bricks = 0; m_lives = 0; m_level = 0; m_score = 0;
   endtask

   // One rising edge of the specified behaviour, using the inputs held at the edge
   task automatic model_step();
      int c = int'(cs);
      int add = 0;
      bit won_now = 1'b0;
      bit lost_now = 1'b0;
      if (m_phase == M_IDLE) begin
         if (is_lvl(c)) m_phase = M_ARM;
      end else if (!is_lvl(c)) begin
         m_phase = M_IDLE;
      end else if (m_phase == M_ARM) begin
         m_bricks = 6 * (c - 2);
         m_lives  = LIVES_INIT;
         m_level  = c;
         m_phase  = M_PLAY;
      end else if (m_phase == M_PLAY) begin
         if (c != m_level) begin
            m_phase = M_ARM;
         end else begin
            if (h && m_bricks > 0) begin
               won_now = (m_bricks == 1);
               m_bricks = m_bricks - 1;
               add += 10;
            end
            if (l && m_lives > 0) begin
               lost_now = (m_lives == 1);
               m_lives = m_lives - 1;
            end
            if (won_now) begin
               m_phase = M_WON;
               add += WIN_BONUS;
            end else if (lost_now) begin
               m_phase = M_LOST;
            end
         end
      end
      if (SCORE_ON) begin
         if (c == 15) m_score = 0;
         else m_score = (m_score + add > 65535) ? 65535 : m_score + add;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; cs = SCR_LS; h = 1'b0; l = 1'b0;
      model_reset();
      #12;
      n_tests++; if (win !== 1'b0) begin n_fail++; $display("FAIL reset_win: got %0d expected 0", win); end
      n_tests++; if (lose !== 1'b0) begin n_fail++; $display("FAIL reset_lose: got %0d expected 0", lose); end
      n_tests++; if (lives !== 2'd0) begin n_fail++; $display("FAIL reset_lives: got %0d expected 0", lives); end
      n_tests++; if (bricks_left !== 6'd0) begin n_fail++; $display("FAIL reset_bricks: got %0d expected 0", bricks_left); end
      n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_win();
      cs = SCR_LS; tick();
      cs = SCR_L1; tick(); tick();
      n_tests++; if (bricks_left !== 6'd6) begin n_fail++; $display("FAIL win_load_bricks: got %0d expected 6", bricks_left); end
      n_tests++; if (lives !== 2'(LIVES_INIT)) begin n_fail++; $display("FAIL win_load_lives: got %0d expected %0d", lives, LIVES_INIT); end
      for (int i = 1; i <= 6; i++) begin
         h = 1'b1; tick(); h = 1'b0;
         n_tests++; if (bricks_left !== 6'(6 - i)) begin n_fail++; $display("FAIL win_bricks_%0d: got %0d expected %0d", i, bricks_left, 6 - i); end
         n_tests++; if (win !== (i == 6)) begin n_fail++; $display("FAIL win_flag_%0d: got %0d expected %0d", i, win, (i == 6)); end
         tick(); tick();
      end
      n_tests++; if (win !== 1'b1) begin n_fail++; $display("FAIL win_hold: got %0d expected 1", win); end
      cs = SCR_LS; tick();
      n_tests++; if (win !== 1'b0) begin n_fail++; $display("FAIL win_release: got %0d expected 0", win); end
   endtask

   task automatic test_lose();
      cs = SCR_L3; tick(); tick();
      n_tests++; if (lives !== 2'd3) begin n_fail++; $display("FAIL lose_load_lives: got %0d expected 3", lives); end
      n_tests++; if (bricks_left !== 6'd18) begin n_fail++; $display("FAIL lose_load_bricks: got %0d expected 18", bricks_left); end
      for (int i = 1; i <= 3; i++) begin
         l = 1'b1; tick(); l = 1'b0;
         n_tests++; if (lives !== 2'(3 - i)) begin n_fail++; $display("FAIL lose_lives_%0d: got %0d expected %0d", i, lives, 3 - i); end
         n_tests++; if (lose !== (i == 3)) begin n_fail++; $display("FAIL lose_flag_%0d: got %0d expected %0d", i, lose, (i == 3)); end
         tick();
      end
      cs = SCR_GO; tick();
      n_tests++; if (lose !== 1'b0) begin n_fail++; $display("FAIL lose_release: got %0d expected 0", lose); end
      l = 1'b1; tick(); l = 1'b0; tick();
      n_tests++; if (lives !== 2'd0) begin n_fail++; $display("FAIL lose_idle_hold: got %0d expected 0", lives); end
   endtask

   task automatic test_both_final();
      cs = SCR_LS; tick();
      cs = SCR_L1; tick(); tick();
      for (int i = 0; i < 5; i++) begin h = 1'b1; tick(); h = 1'b0; end
      for (int i = 0; i < 2; i++) begin l = 1'b1; tick(); l = 1'b0; end
      n_tests++; if ((bricks_left !== 6'd1) || (lives !== 2'd1)) begin n_fail++; $display("FAIL both_pre: got bricks %0d lives %0d expected 1 1", bricks_left, lives); end
      h = 1'b1; l = 1'b1; tick(); h = 1'b0; l = 1'b0;
      n_tests++; if (win !== 1'b1) begin n_fail++; $display("FAIL both_win: got %0d expected 1", win); end
      n_tests++; if (lose !== 1'b0) begin n_fail++; $display("FAIL both_lose: got %0d expected 0", lose); end
      n_tests++; if (lives !== 2'd0) begin n_fail++; $display("FAIL both_lives: got %0d expected 0", lives); end
      cs = SCR_LS; tick();
   endtask

   task automatic test_rearm();
      cs = SCR_L1; tick(); tick();
      h = 1'b1; tick(); h = 1'b0;
      n_tests++; if (bricks_left !== 6'd5) begin n_fail++; $display("FAIL rearm_pre: got %0d expected 5", bricks_left); end
      cs = SCR_L4; tick();
      n_tests++; if (bricks_left !== 6'd5) begin n_fail++; $display("FAIL rearm_arm_cycle: got %0d expected 5", bricks_left); end
      tick();
      n_tests++; if (bricks_left !== 6'd24) begin n_fail++; $display("FAIL rearm_bricks: got %0d expected 24", bricks_left); end
      n_tests++; if (lives !== 2'd3) begin n_fail++; $display("FAIL rearm_lives: got %0d expected 3", lives); end
   endtask

   task automatic test_async_reset();
      cs = SCR_L5; tick();
      h = 1'b1; tick(); h = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      n_tests++; if ({win, lose, lives, bricks_left, score} !== '0) begin n_fail++; $display("FAIL async_rst_outputs: got win %0d lose %0d lives %0d bricks %0d score %0d expected all 0", win, lose, lives, bricks_left, score); end
      cs = SCR_L2;
      #2;
      rst = 1'b0;
      tick();
      n_tests++; if (bricks_left !== 6'd0) begin n_fail++; $display("FAIL async_arm_cycle: got %0d expected 0", bricks_left); end
      tick();
      n_tests++; if (bricks_left !== 6'd12) begin n_fail++; $display("FAIL async_rearm_bricks: got %0d expected 12", bricks_left); end
      n_tests++; if (lives !== 2'd3) begin n_fail++; $display("FAIL async_rearm_lives: got %0d expected 3", lives); end
   endtask

   task automatic test_idle_pulses();
      int exp_b, exp_l, exp_s;
      cs = SCR_LS; tick();
      exp_b = m_bricks; exp_l = m_lives; exp_s = m_score;
      for (int i = 0; i < 4; i++) begin
         h = 1'b1; l = (i % 2) == 0; tick();
      end
      h = 1'b0; l = 1'b0; tick();
      n_tests++; if (bricks_left !== 6'(exp_b)) begin n_fail++; $display("FAIL idle_bricks: got %0d expected %0d", bricks_left, exp_b); end
      n_tests++; if (lives !== 2'(exp_l)) begin n_fail++; $display("FAIL idle_lives: got %0d expected %0d", lives, exp_l); end
      n_tests++; if (score !== 16'(exp_s)) begin n_fail++; $display("FAIL idle_score: got %0d expected %0d", score, exp_s); end
   endtask

   task automatic test_score();
      cs = SCR_SM; tick();
      n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL score_clear0: got %0d expected 0", score); end
      cs = SCR_L1; tick(); tick();
      for (int i = 0; i < 6; i++) begin h = 1'b1; tick(); h = 1'b0; tick(); end
      n_tests++; if (score !== (SCORE_ON ? 16'd160 : 16'd0)) begin n_fail++; $display("FAIL score_l1: got %0d expected %0d", score, SCORE_ON ? 160 : 0); end
      cs = SCR_LS; tick();
      cs = SCR_L2; tick(); tick();
      for (int i = 0; i < 2; i++) begin h = 1'b1; tick(); h = 1'b0; end
      n_tests++; if (score !== (SCORE_ON ? 16'd180 : 16'd0)) begin n_fail++; $display("FAIL score_l2: got %0d expected %0d", score, SCORE_ON ? 180 : 0); end
      cs = SCR_SM; tick();
      n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL score_sm_clear: got %0d expected 0", score); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 1) == 0) cs = 4'($urandom_range(3, 10));
            else cs = 4'($urandom_range(0, 15));
         end
         h = ($urandom_range(0, 9) < 4);
         l = ($urandom_range(0, 9) < 1);
         tick();
         n_tests++; if (win !== (m_phase == M_WON)) begin n_fail++; $display("FAIL rnd_win @%0d: got %0d expected %0d", n, win, (m_phase == M_WON)); end
         n_tests++; if (lose !== (m_phase == M_LOST)) begin n_fail++; $display("FAIL rnd_lose @%0d: got %0d expected %0d", n, lose, (m_phase == M_LOST)); end
         n_tests++; if (lives !== 2'(m_lives)) begin n_fail++; $display("FAIL rnd_lives @%0d: got %0d expected %0d", n, lives, m_lives); end
         n_tests++; if (bricks_left !== 6'(m_bricks)) begin n_fail++; $display("FAIL rnd_bricks @%0d: got %0d expected %0d", n, bricks_left, m_bricks); end
         n_tests++; if (score !== 16'(m_score)) begin n_fail++; $display("FAIL rnd_score @%0d: got %0d expected %0d", n, score, m_score); end
      end
      h = 1'b0; l = 1'b0;
   endtask

   initial begin
      test_reset();
      test_win();
      test_lose();
      test_both_final();
      test_rearm();
      test_async_reset();
      test_idle_pulses();
      test_score();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
